// File: rtl/pl_pkg.sv
// ---------------------------------------------------------------------------
// pl_pkg
// Shared definitions for the generic pipeline stage register.
//   ctrl_t            : decoded control bundle carried between stages
//   *_CTRL_W/*_DATA_W : bundle widths for each pipeline boundary
//   KILL_CNT_W        : default width of the flush kill counter
//   stage_state_e     : occupancy state used when the skid entry is built
// ---------------------------------------------------------------------------
package pl_pkg;

    typedef struct packed {
        logic       regwr;
        logic [1:0] result_sel;
        logic       memwr;
        logic       jump;
        logic       branch;
        logic       jalr;
        logic [3:0] alu_op;
        logic       alu_sgn;
        logic [2:0] func3;
    } ctrl_t;

    localparam int CTRL_BUNDLE_W = $bits(ctrl_t);

    // The control bundle is padded to 16 bits at every boundary so that
    // fields can be added without touching the stage instances.
    localparam int IFID_CTRL_W  = 16;
    localparam int IFID_DATA_W  = 64;   // pc, instruction
    localparam int IDEX_CTRL_W  = 16;
    localparam int IDEX_DATA_W  = 160;  // rs1, rs2, pc, imm, rd/pc+4
    localparam int EXMEM_CTRL_W = 16;
    localparam int EXMEM_DATA_W = 128;  // alu result, store data, pc+4, rd
    localparam int MEMWB_CTRL_W = 16;
    localparam int MEMWB_DATA_W = 96;   // alu result, load data, pc+4

    localparam int KILL_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

endpackage

// File: rtl/pl_skid_entry.sv
// ---------------------------------------------------------------------------
// pl_skid_entry
// One holding register (valid bit + control + data) used as the main output
// register and, optionally, as the skid register of pl_stage_reg.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset (clears valid, ctrl and data)
//   clr_i      : squash; valid and ctrl cleared, data cleared if CLEAR_DATA
//   load_i     : capture ld_ctrl_i/ld_data_i and mark valid
//   drop_i     : mark empty, contents held
//   ld_ctrl_i  : control bundle to capture
//   ld_data_i  : data bundle to capture
//   valid_o    : entry holds a beat
//   ctrl_o     : stored control bundle
//   data_o     : stored data bundle
// Priority: reset > clr_i > load_i > drop_i.
// ---------------------------------------------------------------------------
module pl_skid_entry
    import pl_pkg::*;
#(
    parameter int CW         = IDEX_CTRL_W,
    parameter int DW         = IDEX_DATA_W,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic          drop_i,
    input  logic [CW-1:0] ld_ctrl_i,
    input  logic [DW-1:0] ld_data_i,
    output logic          valid_o,
    output logic [CW-1:0] ctrl_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q, valid_d;
    logic [CW-1:0] ctrl_q,  ctrl_d;
    logic [DW-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (clr_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            if (CLEAR_DATA) begin
                data_d = '0;
            end
        end else if (load_i) begin
            valid_d = 1'b1;
            ctrl_d  = ld_ctrl_i;
            data_d  = ld_data_i;
        end else if (drop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pl_stage_reg.sv
// ---------------------------------------------------------------------------
// pl_stage_reg
// Generic valid/ready pipeline register between two stages, with flush and a
// saturating count of squashed entries.
// Build option: define PL_STAGE_SKID_EN to add a one-entry skid register so
// that in_ready comes straight from a flop (no out_ready -> in_ready path).
// Without it the stage is a single register with combinational in_ready.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   flush     : squash all stored entries (beat offered this cycle dropped)
//   in_valid  : upstream beat valid
//   in_ready  : stage can accept a beat
//   in_ctrl   : upstream control bundle
//   in_data   : upstream data bundle
//   out_valid : downstream beat valid
//   out_ready : downstream accepts a beat
//   out_ctrl  : registered control bundle
//   out_data  : registered data bundle
//   kill_cnt  : saturating count of valid entries killed by flush
// ---------------------------------------------------------------------------
module pl_stage_reg
    import pl_pkg::*;
#(
    parameter int CTRL_W     = IDEX_CTRL_W,
    parameter int DATA_W     = IDEX_DATA_W,
    parameter bit CLEAR_DATA = 1'b1,
    parameter int CNT_W      = KILL_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  kill_cnt
);

    localparam int SUM_W = CNT_W + 1;

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              main_load;
    logic              main_drop;
    logic [CTRL_W-1:0] main_ld_ctrl;
    logic [DATA_W-1:0] main_ld_data;

    logic              in_xfer;
    logic              out_xfer;
    logic [1:0]        stored_cnt;

    // A beat offered during a flush is dropped, so it never counts as taken.
    assign in_xfer  = in_valid & in_ready & ~flush;
    assign out_xfer = main_valid & out_ready;

    pl_skid_entry #(
        .CW         (CTRL_W),
        .DW         (DATA_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_main (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (flush),
        .load_i    (main_load),
        .drop_i    (main_drop),
        .ld_ctrl_i (main_ld_ctrl),
        .ld_data_i (main_ld_data),
        .valid_o   (main_valid),
        .ctrl_o    (main_ctrl),
        .data_o    (main_data)
    );

`ifdef PL_STAGE_SKID_EN

    stage_state_e      state_q, state_d;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              skid_load;
    logic              skid_drop;
    logic              main_from_skid;

    pl_skid_entry #(
        .CW         (CTRL_W),
        .DW         (DATA_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (flush),
        .load_i    (skid_load),
        .drop_i    (skid_drop),
        .ld_ctrl_i (in_ctrl),
        .ld_data_i (in_data),
        .valid_o   (skid_valid),
        .ctrl_o    (skid_ctrl),
        .data_o    (skid_data)
    );

    // Ready depends only on the state flop: the skid slot absorbs the beat
    // that arrives in the cycle downstream stalls.
    assign in_ready = (state_q != ST_TWO);

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_drop      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_drop      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_load = 1'b1;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (in_xfer) begin
                        skid_load = 1'b1;
                        state_d   = ST_TWO;
                    end else if (out_xfer) begin
                        main_drop = 1'b1;
                        state_d   = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only the drain can happen.
                    if (out_xfer) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_drop      = 1'b1;
                        state_d        = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign main_ld_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_ld_data = main_from_skid ? skid_data : in_data;
    assign stored_cnt   = {1'b0, main_valid} + {1'b0, skid_valid};

`else

    assign in_ready     = ~main_valid | out_ready;
    assign main_load    = in_xfer;
    assign main_drop    = out_xfer & ~in_xfer;
    assign main_ld_ctrl = in_ctrl;
    assign main_ld_data = in_data;
    assign stored_cnt   = {1'b0, main_valid};

`endif

    // Kill counter: at most 2 is added per flush, so a carry out of CNT_W
    // bits always means the count has reached or passed its ceiling.
    logic [CNT_W-1:0] kill_q, kill_d;
    logic [SUM_W-1:0] kill_sum;

    always_comb begin
        kill_sum = SUM_W'(kill_q) + SUM_W'(stored_cnt);
        kill_d   = kill_q;
        if (flush) begin
            kill_d = kill_sum[CNT_W] ? {CNT_W{1'b1}} : kill_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kill_q <= '0;
        end else begin
            kill_q <= kill_d;
        end
    end

    assign out_valid = main_valid;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;
    assign kill_cnt  = kill_q;

endmodule

// File: tb/tb_pl_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pl_stage_reg
// Three instances share one stimulus: default (clear data, 8-bit counter),
// data-hold on flush, and a 2-bit kill counter. A queue-based occupancy
// model predicts every output each cycle; a vector table and hand-written
// sequences check the directed corner cases.
// ---------------------------------------------------------------------------
module tb_pl_stage_reg;

    localparam int CW = 16;
    localparam int DW = 32;

`ifdef PL_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          rdy_a, rdy_b, rdy_c;
    logic          ov_a, ov_b, ov_c;
    logic [CW-1:0] oc_a, oc_b, oc_c;
    logic [DW-1:0] od_a, od_b, od_c;
    logic [7:0]    k_a, k_b;
    logic [1:0]    k_c;

    always #5 clk = ~clk;

    pl_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov_a), .out_ready(out_ready),
        .out_ctrl(oc_a), .out_data(od_a), .kill_cnt(k_a));

    pl_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b0), .CNT_W(8)) dut_nc (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov_b), .out_ready(out_ready),
        .out_ctrl(oc_b), .out_data(od_b), .kill_cnt(k_b));

    pl_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_c),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov_c), .out_ready(out_ready),
        .out_ctrl(oc_c), .out_data(od_c), .kill_cnt(k_c));

    int tests = 0;
    int fails = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    logic [CW-1:0] mq_c[$];
    logic [DW-1:0] mq_d[$];
    logic [CW-1:0] m_ctrl;
    logic [DW-1:0] m_data, m_data_nc;
    int            m_kill;

    function automatic void model_reset();
        mq_c.delete();
        mq_d.delete();
        m_ctrl = '0; m_data = '0; m_data_nc = '0; m_kill = 0;
    endfunction

    function automatic logic model_ready();
        if (SKID) return (mq_c.size() < 2);
        return (mq_c.size() == 0) || out_ready;
    endfunction

    // Apply the stage's rules for one rising edge with the current inputs.
    function automatic void model_edge();
        logic rdy;
        logic ox;
        rdy = model_ready();
        if (!rst_n) begin
            model_reset();
        end else if (flush) begin
            m_kill += mq_c.size();
            mq_c.delete();
            mq_d.delete();
            m_ctrl = '0;
            m_data = '0;
        end else begin
            ox = (mq_c.size() > 0) && out_ready;
            if (ox) begin
                void'(mq_c.pop_front());
                void'(mq_d.pop_front());
            end
            if (in_valid && rdy) begin
                mq_c.push_back(in_ctrl);
                mq_d.push_back(in_data);
            end
            if (mq_c.size() > 0) begin
                m_ctrl = mq_c[0];
                m_data = mq_d[0];
                m_data_nc = mq_d[0];
            end
        end
    endfunction

    // Called at the falling edge: compare, then advance over the next rising edge.
    task automatic model_step();
        logic ev;
        ev = (mq_c.size() > 0);
        check("m_valid",   ov_a, ev);
        check("m_ready",   rdy_a, model_ready());
        check("m_ctrl",    oc_a, m_ctrl);
        check("m_data",    od_a, m_data);
        check("m_data_nc", od_b, m_data_nc);
        check("m_kill",    k_a, (m_kill > 255) ? 255 : m_kill);
        check("m_kill_sat", k_c, (m_kill > 3) ? 3 : m_kill);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(logic r, logic f, logic iv, logic orr, logic [CW-1:0] c, logic [DW-1:0] d);
        rst_n = r; flush = f; in_valid = iv; out_ready = orr; in_ctrl = c; in_data = d;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          r, f, iv, orr;
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        logic          ev;
        logic [CW-1:0] ec;
        logic [DW-1:0] ed, ed_nc;
        logic          er_base, er_skid;
        logic [7:0]    ek;
    } vec_t;

    vec_t vt[12];
    logic [1:0] sat_exp[5];

    initial begin
        // r f iv or  ctrl     data     | ev ctrl     data     data_nc  rdyB rdyS kill
        vt[0]  = '{0,0,1,1, 16'h00A5, 32'h1234, 0, 16'h0000, 32'h0,    32'h0,    1, 1, 0};
        vt[1]  = '{1,0,1,1, 16'h00A5, 32'h1234, 0, 16'h0000, 32'h0,    32'h0,    1, 1, 0};
        vt[2]  = '{1,0,0,1, 16'h0000, 32'h0,    1, 16'h00A5, 32'h1234, 32'h1234, 1, 1, 0};
        vt[3]  = '{1,0,1,1, 16'h0011, 32'h11,   0, 16'h00A5, 32'h1234, 32'h1234, 1, 1, 0};
        vt[4]  = '{1,0,1,0, 16'h0022, 32'h22,   1, 16'h0011, 32'h11,   32'h11,   0, 1, 0};
        vt[5]  = '{1,0,1,0, 16'h0022, 32'h22,   1, 16'h0011, 32'h11,   32'h11,   0, 0, 0};
        vt[6]  = '{1,0,1,0, 16'h0022, 32'h22,   1, 16'h0011, 32'h11,   32'h11,   0, 0, 0};
        vt[7]  = '{1,0,1,1, 16'h0022, 32'h22,   1, 16'h0011, 32'h11,   32'h11,   1, 0, 0};
        vt[8]  = '{1,0,0,0, 16'h0000, 32'h0,    1, 16'h0022, 32'h22,   32'h22,   0, 1, 0};
        vt[9]  = '{1,1,1,0, 16'h0033, 32'h33,   1, 16'h0022, 32'h22,   32'h22,   0, 1, 0};
        vt[10] = '{1,0,0,1, 16'h0000, 32'h0,    0, 16'h0000, 32'h0,    32'h22,   1, 1, 1};
        vt[11] = '{1,0,0,1, 16'h0000, 32'h0,    0, 16'h0000, 32'h0,    32'h22,   1, 1, 1};
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        drive(0, 0, 0, 0, '0, '0);
        @(posedge clk); #1;
        model_reset();

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].r, vt[i].f, vt[i].iv, vt[i].orr, vt[i].c, vt[i].d);
            @(negedge clk);
            $display("[TB] vec %0d: valid=%0b ctrl=%h data=%h ready=%0b kill=%0d",
                     i, ov_a, oc_a, od_a, rdy_a, k_a);
            check("t_valid",   ov_a, vt[i].ev);
            check("t_ctrl",    oc_a, vt[i].ec);
            check("t_data",    od_a, vt[i].ed);
            check("t_data_nc", od_b, vt[i].ed_nc);
            check("t_ready",   rdy_a, SKID ? vt[i].er_skid : vt[i].er_base);
            check("t_kill",    k_a, vt[i].ek);
            model_step();
        end

        // Saturation: 2-bit counter after five single-entry flushes.
        drive(0, 0, 0, 0, '0, '0);
        @(negedge clk); model_step();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, 0, 16'h0040 + 16'(i), 32'(i));
            @(negedge clk); model_step();
            drive(1, 1, 0, 0, '0, '0);
            @(negedge clk); model_step();
            drive(1, 0, 0, 0, '0, '0);
            @(negedge clk);
            $display("[TB] sat flush %0d: kill2=%0d kill8=%0d", i, k_c, k_a);
            check("sat_kill2", k_c, sat_exp[i]);
            check("sat_kill8", k_a, 8'(i + 1));
            check("sat_valid", ov_c, 1'b0);
            model_step();
        end

`ifdef PL_STAGE_SKID_EN
        // Skid: two beats while stalled, drained in order, then a double kill.
        drive(0, 0, 0, 0, '0, '0);
        @(negedge clk); model_step();
        drive(1, 0, 1, 0, 16'h0001, 32'hA);
        @(negedge clk); model_step();
        drive(1, 0, 1, 0, 16'h0002, 32'hB);
        @(negedge clk); model_step();
        drive(1, 0, 0, 0, '0, '0);
        @(negedge clk);
        $display("[TB] skid full: ready=%0b ctrl=%h", rdy_a, oc_a);
        check("skid_ready_full", rdy_a, 1'b0);
        check("skid_hold_ctrl", oc_a, 16'h0001);
        model_step();
        drive(1, 0, 0, 1, '0, '0);
        @(negedge clk);
        $display("[TB] skid drain 1: valid=%0b ctrl=%h", ov_a, oc_a);
        check("skid_first", oc_a, 16'h0001);
        model_step();
        @(negedge clk);
        $display("[TB] skid drain 2: valid=%0b ctrl=%h", ov_a, oc_a);
        check("skid_second", oc_a, 16'h0002);
        check("skid_second_v", ov_a, 1'b1);
        model_step();
        drive(1, 0, 1, 0, 16'h0003, 32'hC);
        @(negedge clk); model_step();
        drive(1, 0, 1, 0, 16'h0004, 32'hD);
        @(negedge clk); model_step();
        drive(1, 1, 0, 0, '0, '0);
        @(negedge clk); model_step();
        drive(1, 0, 0, 1, '0, '0);
        @(negedge clk);
        $display("[TB] skid flush: kill=%0d valid=%0b", k_a, ov_a);
        check("skid_kill2", k_a, 8'd2);
        check("skid_flush_v", ov_a, 1'b0);
        model_step();
`endif

        // Randomised traffic against the model.
        drive(0, 0, 0, 0, '0, '0);
        @(negedge clk); model_step();
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0),
                  CW'($urandom), DW'($urandom));
            @(negedge clk);
            if (ov_a && out_ready && rst_n && !flush)
                $display("[TB] rnd %0d: out beat ctrl=%h data=%h", i, oc_a, od_a);
            model_step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
